// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Sequencer for an external up-counter (clk/en/rst/out). Produces periods of
//   P+1 cycles (counter runs 0..P), repeated R times or free-running (R=0).
//   Emits a wrap strobe per period, a done strobe after the R-th period and an
//   err strobe for rejected starts. Optional arming on sync_in before the run.
//
// Ports
//   clk, rst_n           clock / asynchronous active-low reset
//   start, stop          run request (IDLE only) / abort (any non-IDLE state)
//   sync_in              arm trigger, used only when ARM_ON_SYNC=1
//   period, num_periods  terminal count P and repetitions R, latched on start
//   cnt_val              counter output
//   cnt_en, cnt_rst      counter enable / counter synchronous reset
//   busy, wrap, done, err  status and 1-cycle strobes
//   rep_cnt              periods completed in the current run
module counter_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int REP_WIDTH   = 16,
    parameter int ARM_ON_SYNC = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  sync_in,
    input  logic [DATA_WIDTH-1:0] period,
    input  logic [REP_WIDTH-1:0]  num_periods,
    input  logic [DATA_WIDTH-1:0] cnt_val,
    output logic                  cnt_en,
    output logic                  cnt_rst,
    output logic                  busy,
    output logic                  wrap,
    output logic                  done,
    output logic                  err,
    output logic [REP_WIDTH-1:0]  rep_cnt
);

    typedef enum logic [2:0] {IDLE, ARMED, CLEAR, RUN, DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] per_q;
    logic [REP_WIDTH-1:0]  reps_q;
    logic [DATA_WIDTH-1:0] per_m1;
    logic                  last_wrap;

    // Outputs are registered, so the decision to wrap is taken one cycle early
    // (counter at P-1); the wrap cycle itself then sees the counter at P.
    assign per_m1    = per_q - DATA_WIDTH'(1);
    // In the wrap cycle rep_cnt already holds the incremented count.
    assign last_wrap = wrap && (reps_q != '0) && (rep_cnt == reps_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            per_q   <= '0;
            reps_q  <= '0;
            rep_cnt <= '0;
            cnt_en  <= 1'b0;
            cnt_rst <= 1'b1;
            busy    <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            if (start && state != IDLE)
                err <= 1'b1;

            // stop outranks wrap, sync_in and the DONE transition
            if (stop && state != IDLE) begin
                state   <= IDLE;
                cnt_en  <= 1'b0;
                cnt_rst <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_en  <= 1'b0;
                        cnt_rst <= 1'b0;
                        if (start) begin
                            if (period == '0) begin
                                err <= 1'b1;
                            end else begin
                                per_q   <= period;
                                reps_q  <= num_periods;
                                rep_cnt <= '0;
                                busy    <= 1'b1;
                                if (ARM_ON_SYNC != 0) begin
                                    state <= ARMED;
                                end else begin
                                    state   <= CLEAR;
                                    cnt_rst <= 1'b1;
                                end
                            end
                        end
                    end
                    ARMED: begin
                        cnt_en <= 1'b0;
                        if (sync_in) begin
                            state   <= CLEAR;
                            cnt_rst <= 1'b1;
                        end
                    end
                    CLEAR: begin
                        state   <= RUN;
                        cnt_rst <= 1'b0;
                        cnt_en  <= 1'b1;
                    end
                    RUN: begin
                        if (last_wrap) begin
                            state   <= DONE;
                            cnt_en  <= 1'b0;
                            cnt_rst <= 1'b0;
                            done    <= 1'b1;
                        end else if (cnt_val == per_m1) begin
                            wrap    <= 1'b1;
                            cnt_rst <= 1'b1;
                            rep_cnt <= rep_cnt + REP_WIDTH'(1);
                        end else begin
                            cnt_rst <= 1'b0;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cnt_en  <= 1'b0;
                        cnt_rst <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        cnt_en  <= 1'b0;
                        cnt_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
module tb_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0, stop = 1'b0, sync_in = 1'b0;
    logic [7:0]  period = 8'd0;
    logic [15:0] num_periods = 16'd0;

    // instance A: ARM_ON_SYNC=0, instance B: ARM_ON_SYNC=1
    logic        en_a, rst_a, busy_a, wrap_a, done_a, err_a;
    logic        en_b, rst_b, busy_b, wrap_b, done_b, err_b;
    logic [15:0] rep_a, rep_b;
    logic [7:0]  val_a = 8'd0, val_b = 8'd0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // behavioural counters the sequencer drives (rst has priority over en)
    always @(posedge clk) begin
        if (rst_a) val_a <= 8'd0; else if (en_a) val_a <= val_a + 8'd1;
        if (rst_b) val_b <= 8'd0; else if (en_b) val_b <= val_b + 8'd1;
    end

    counter_ctrl #(.DATA_WIDTH(8), .REP_WIDTH(16), .ARM_ON_SYNC(0)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop), .sync_in(sync_in),
        .period(period), .num_periods(num_periods), .cnt_val(val_a),
        .cnt_en(en_a), .cnt_rst(rst_a), .busy(busy_a), .wrap(wrap_a),
        .done(done_a), .err(err_a), .rep_cnt(rep_a));

    counter_ctrl #(.DATA_WIDTH(8), .REP_WIDTH(16), .ARM_ON_SYNC(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop), .sync_in(sync_in),
        .period(period), .num_periods(num_periods), .cnt_val(val_b),
        .cnt_en(en_b), .cnt_rst(rst_b), .busy(busy_b), .wrap(wrap_b),
        .done(done_b), .err(err_b), .rep_cnt(rep_b));

    typedef struct {
        logic        st;
        logic [7:0]  per;
        logic [15:0] np;
        logic [5:0]  flags;   // {rst, en, wrap, done, err, busy}
        logic [7:0]  val;
        logic [15:0] rep;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, nw, first, last, gapbad, ndone, enbad;

        // P=3, R=2 run; period/num_periods change mid-run and a busy start at row 6
        tbl[0]  = '{1'b1, 8'd3, 16'd2, 6'b000000, 8'd0, 16'd0};
        tbl[1]  = '{1'b0, 8'd7, 16'd5, 6'b100001, 8'd0, 16'd0};
        tbl[2]  = '{1'b0, 8'd7, 16'd5, 6'b010001, 8'd0, 16'd0};
        tbl[3]  = '{1'b0, 8'd7, 16'd5, 6'b010001, 8'd1, 16'd0};
        tbl[4]  = '{1'b0, 8'd7, 16'd5, 6'b010001, 8'd2, 16'd0};
        tbl[5]  = '{1'b0, 8'd7, 16'd5, 6'b111001, 8'd3, 16'd1};
        tbl[6]  = '{1'b1, 8'd0, 16'd5, 6'b010001, 8'd0, 16'd1};
        tbl[7]  = '{1'b0, 8'd7, 16'd5, 6'b010011, 8'd1, 16'd1};
        tbl[8]  = '{1'b0, 8'd7, 16'd5, 6'b010001, 8'd2, 16'd1};
        tbl[9]  = '{1'b0, 8'd7, 16'd5, 6'b111001, 8'd3, 16'd2};
        tbl[10] = '{1'b0, 8'd7, 16'd5, 6'b000101, 8'd0, 16'd2};
        tbl[11] = '{1'b0, 8'd7, 16'd5, 6'b000000, 8'd0, 16'd2};
        tbl[12] = '{1'b0, 8'd7, 16'd5, 6'b000000, 8'd0, 16'd2};

        // ---- reset values ----
        step(); step(); step();
        chk("reset_flags_a", {rst_a, en_a, wrap_a, done_a, err_a, busy_a}, 6'b100000);
        chk("reset_rep_a", rep_a, 16'd0);
        chk("reset_flags_b", {rst_b, en_b, busy_b}, 3'b100);
        rst_n = 1'b1;
        chk("release_rst_hold", rst_a, 1'b1);
        step();
        chk("release_rst_clear", rst_a, 1'b0);

        // ---- async reset mid-run ----
        period = 8'd5; num_periods = 16'd0; start_a = 1'b1;
        step(); start_a = 1'b0;
        step(); step(); step(); step();
        chk("midrun_busy", {en_a, busy_a}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {rst_a, en_a, busy_a, wrap_a}, 4'b1000);
        step(); step();
        rst_n = 1'b1;
        chk("async_reset_rep", rep_a, 16'd0);
        step();
        chk("post_reset_rst", {rst_a, busy_a}, 2'b00);

        // ---- table: P=3, R=2 ----
        for (int i = 0; i < 13; i++) begin
            chk($sformatf("tbl%0d_flags", i), {rst_a, en_a, wrap_a, done_a, err_a, busy_a}, tbl[i].flags);
            chk($sformatf("tbl%0d_val", i), val_a, tbl[i].val);
            chk($sformatf("tbl%0d_rep", i), rep_a, tbl[i].rep);
            start_a = tbl[i].st; period = tbl[i].per; num_periods = tbl[i].np;
            step();
        end
        start_a = 1'b0;

        // ---- free run P=4, R=0: 20 periods then stop ----
        period = 8'd4; num_periods = 16'd0; start_a = 1'b1;
        step(); start_a = 1'b0;
        cyc = 1; nw = 0; first = 0; last = 0; gapbad = 0; ndone = 0;
        while (nw < 20 && cyc < 300) begin
            if (done_a) ndone++;
            if (wrap_a) begin
                if (nw == 0) first = cyc;
                else if (cyc - last != 5) gapbad++;
                last = cyc;
                nw++;
            end
            step(); cyc++;
        end
        chk("free_wraps", nw, 20);
        chk("free_first_wrap", first, 6);
        chk("free_gap_errors", gapbad, 0);
        chk("free_no_done", ndone, 0);
        chk("free_rep", rep_a, 16'd20);
        stop = 1'b1;
        step(); stop = 1'b0;
        chk("stop_cycle", {rst_a, en_a, done_a, busy_a}, 4'b1000);
        step();
        chk("stop_after", {rst_a, done_a, busy_a}, 3'b000);
        chk("stop_rep_kept", rep_a, 16'd20);

        // ---- armed instance: P=2, R=1 ----
        period = 8'd2; num_periods = 16'd1; start_b = 1'b1;
        step(); start_b = 1'b0;
        enbad = 0;
        for (int i = 0; i < 10; i++) begin
            if (en_b !== 1'b0 || busy_b !== 1'b1) enbad++;
            step();
        end
        chk("armed_hold", enbad, 0);
        sync_in = 1'b1;
        step(); sync_in = 1'b0;
        chk("sync_clear", {rst_b, en_b}, 2'b10);
        step();
        chk("sync_run", {en_b, val_b}, {1'b1, 8'd0});
        step(); step();
        chk("sync_wrap", {wrap_b, val_b}, {1'b1, 8'd2});
        step();
        chk("sync_done", {done_b, busy_b}, 2'b11);
        step();
        chk("sync_idle", {done_b, busy_b}, 2'b00);
        chk("sync_rep", rep_b, 16'd1);

        // ---- start with period 0 ----
        period = 8'd0; num_periods = 16'd3; start_a = 1'b1;
        step(); start_a = 1'b0;
        chk("zero_period_err", {err_a, busy_a}, 2'b10);
        step();
        chk("zero_period_after", {err_a, busy_a}, 2'b00);

        // ---- stop collides with final wrap: P=1, R=1 ----
        period = 8'd1; num_periods = 16'd1; start_a = 1'b1;
        step(); start_a = 1'b0;
        chk("coll_clear", rst_a, 1'b1);
        step(); step();
        chk("coll_wrap", {wrap_a, val_a}, {1'b1, 8'd1});
        stop = 1'b1;
        step(); stop = 1'b0;
        chk("coll_stop", {rst_a, en_a, done_a, busy_a}, 4'b1000);
        chk("coll_rep", rep_a, 16'd1);
        step();
        chk("coll_after", {rst_a, done_a, busy_a, val_a}, {3'b000, 8'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
